// File: rtl/debug_uart_tx_buffer.sv
// Debug UART transmit buffer: circular byte FIFO drained by a handshake
// sequencer that issues bytes to a UART transmitter and guards its done window.
module debug_uart_tx_buffer #(
    parameter int DEPTH_LOG2   = 4,
    parameter int TIMEOUT_CLKS = 15
) (
    input  logic                i_Clock,
    input  logic                i_Rst_n,
    input  logic                i_Wr_En,
    input  logic [7:0]          i_Wr_Data,
    input  logic                i_Clr_Ovf,
    input  logic                i_Tx_Active,
    input  logic                i_Tx_Done,
    output logic                o_Tx_DV,
    output logic [7:0]          o_Tx_Byte,
    output logic                o_Full,
    output logic                o_Empty,
    output logic [DEPTH_LOG2:0] o_Level,
    output logic                o_Overflow,
    output logic                o_Timeout,
    output logic                o_Busy,
    output logic                o_Byte_Sent
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1) + 1;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]    TMO_LAST   = CNT_W'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      tmo_cnt;
    logic                  wr_accept;
    logic                  ovf_event;
    logic                  pop;
    logic                  byte_done;
    logic                  timeout_hit;

    assign o_Full    = (o_Level == FULL_LEVEL);
    assign o_Empty   = (o_Level == '0);
    assign o_Busy    = (state != S_IDLE);
    assign wr_accept = i_Wr_En && !o_Full;
    assign ovf_event = i_Wr_En && o_Full;

    // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        byte_done   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (!o_Empty && !i_Tx_Active && !i_Tx_Done) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (i_Tx_Active) begin
                    state_next = S_WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    byte_done  = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP:   if (!i_Tx_Done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking in sequential blocks so every register sees pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // NOTE: storage is not reset; pointers and level decide what is visible.
    always_ff @(posedge i_Clock) begin
        if (i_Rst_n && wr_accept) mem[wr_ptr] <= i_Wr_Data;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_Level     <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
            o_Byte_Sent <= 1'b0;
            o_Overflow  <= 1'b0;
            o_Timeout   <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            o_Tx_DV     <= pop;
            o_Byte_Sent <= byte_done;
            if (wr_accept) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop) begin
                o_Tx_Byte <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({wr_accept, pop})
                2'b10:   o_Level <= o_Level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   o_Level <= o_Level - (DEPTH_LOG2 + 1)'(1);
                default: o_Level <= o_Level;
            endcase
            // A set event in the same cycle as a clear request wins.
            if (ovf_event)      o_Overflow <= 1'b1;
            else if (i_Clr_Ovf) o_Overflow <= 1'b0;
            if (timeout_hit)    o_Timeout  <= 1'b1;
            else if (i_Clr_Ovf) o_Timeout  <= 1'b0;
            if (state == S_ISSUE)
                tmo_cnt <= '0;
            else if (state == S_WAIT_BUSY && !i_Tx_Active && !timeout_hit)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_debug_uart_tx_buffer.sv
// Bench for debug_uart_tx_buffer: transaction-level FIFO/handshake model with a
// per-cycle compare, a scripted transmitter stand-in, and pinned literal cases.
module tb_debug_uart_tx_buffer;
    localparam int DEPTH_LOG2   = 4;
    localparam int DEPTH        = 16;
    localparam int TIMEOUT_CLKS = 15;
    localparam int CLKS_PER_BIT = 4;

    logic       i_Clock = 1'b0;
    logic       rst_n, wr_en, clr_ovf, tx_done;
    logic [7:0] wr_data;
    logic       xmt_active, hold_active, tx_active;
    logic       o_Tx_DV, o_Full, o_Empty, o_Overflow, o_Timeout, o_Busy, o_Byte_Sent;
    logic [7:0] o_Tx_Byte;
    logic [DEPTH_LOG2:0] o_Level;

    assign tx_active = hold_active | xmt_active;

    debug_uart_tx_buffer #(.DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
        .i_Clock(i_Clock), .i_Rst_n(rst_n), .i_Wr_En(wr_en), .i_Wr_Data(wr_data),
        .i_Clr_Ovf(clr_ovf), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .o_Full(o_Full), .o_Empty(o_Empty),
        .o_Level(o_Level), .o_Overflow(o_Overflow), .o_Timeout(o_Timeout),
        .o_Busy(o_Busy), .o_Byte_Sent(o_Byte_Sent)
    );

    always #5 i_Clock = ~i_Clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         dv_cnt = 0;
    int         sent_cnt = 0;
    bit         tx_dead = 1'b0;
    bit         tx_rand = 1'b0;
    int         act_len_fix = 3;
    logic [9:0] last_frame = '0;
    logic [7:0] cap[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int  n;
        bit  idle;
        n = 0;
        idle = o_Empty && !o_Busy && !tx_active && !tx_done;
        while (!idle && n < budget) begin
            tick();
            n++;
            idle = o_Empty && !o_Busy && !tx_active && !tx_done;
        end
        check({name, "_reach_idle"}, 32'(idle), 1);
    endtask

    // Transmitter stand-in: answers each DV with optional delay, an active
    // period, then a two-cycle done pulse; it may also ignore a DV entirely.
    initial begin : xmtr
        int d, len;
        xmt_active = 1'b0;
        tx_done = 1'b0;
        forever begin
            tick();
            if (rst_n && o_Tx_DV === 1'b1 && !tx_dead && !(tx_rand && $urandom_range(7) == 0)) begin
                cap.push_back(o_Tx_Byte);
                last_frame = {1'b1, o_Tx_Byte, 1'b0};
                d   = tx_rand ? int'($urandom_range(2)) : 0;
                len = tx_rand ? int'($urandom_range(6, 2)) : act_len_fix;
                repeat (d) tick();
                xmt_active = 1'b1;
                repeat (len) tick();
                xmt_active = 1'b0;
                tx_done = 1'b1;
                repeat (2) tick();
                tx_done = 1'b0;
            end
        end
    end

    // Reference: queue of accepted bytes plus the handshake phase
    // (0 idle, 1 issue pulse, 2 awaiting active, 3 awaiting done, 4 done window).
    initial begin : model
        logic [7:0] q[$];
        int         phase, waited;
        bit         chk_en, was_full, do_pop, tmo_ev, ovf_ev;
        logic       m_dv, m_sent, m_ovf, m_tmo;
        logic [7:0] m_byte;
        phase = 0; waited = 0; chk_en = 0;
        m_dv = 0; m_sent = 0; m_ovf = 0; m_tmo = 0; m_byte = 0;
        forever begin
            @(posedge i_Clock);
            if (!rst_n) begin
                q.delete();
                phase = 0; waited = 0; chk_en = 1;
                m_dv = 0; m_sent = 0; m_ovf = 0; m_tmo = 0; m_byte = 8'h00;
            end else begin
                was_full = (q.size() == DEPTH);
                do_pop   = (phase == 0) && (q.size() > 0) && !tx_active && !tx_done;
                ovf_ev   = wr_en && was_full;
                tmo_ev   = 0;
                m_dv     = do_pop;
                m_sent   = 0;
                if (do_pop) m_byte = q.pop_front();
                if (wr_en && !was_full) q.push_back(wr_data);
                case (phase)
                    0: if (do_pop) phase = 1;
                    1: begin phase = 2; waited = 0; end
                    2: begin
                        if (tx_active) phase = 3;
                        else begin
                            waited++;
                            if (waited == TIMEOUT_CLKS + 1) begin tmo_ev = 1; phase = 0; end
                        end
                    end
                    3: if (tx_done) begin m_sent = 1; phase = 4; end
                    default: if (!tx_done) phase = 0;
                endcase
                m_ovf = ovf_ev || (m_ovf && !clr_ovf);
                m_tmo = tmo_ev || (m_tmo && !clr_ovf);
            end
            @(negedge i_Clock);
            if (o_Tx_DV === 1'b1) dv_cnt++;
            if (o_Byte_Sent === 1'b1) sent_cnt++;
            if (chk_en) begin
                check("level",     32'(o_Level),     32'(q.size()));
                check("full",      32'(o_Full),      32'(q.size() == DEPTH));
                check("empty",     32'(o_Empty),     32'(q.size() == 0));
                check("busy",      32'(o_Busy),      32'(phase != 0));
                check("tx_dv",     32'(o_Tx_DV),     32'(m_dv));
                check("tx_byte",   32'(o_Tx_Byte),   32'(m_byte));
                check("byte_sent", 32'(o_Byte_Sent), 32'(m_sent));
                check("overflow",  32'(o_Overflow),  32'(m_ovf));
                check("timeout",   32'(o_Timeout),   32'(m_tmo));
            end
        end
    end

    initial begin : stim
        int base_dv, base_sent, n;
        rst_n = 1'b0; wr_en = 1'b1; wr_data = 8'h3C; clr_ovf = 1'b0; hold_active = 1'b0;
        repeat (3) tick();
        check("rst_level", 32'(o_Level), 0);
        check("rst_empty", 32'(o_Empty), 1);
        check("rst_byte",  32'(o_Tx_Byte), 0);
        wr_en = 1'b0; rst_n = 1'b1;
        tick();
        check("rst_writes_ignored", 32'(o_Empty), 1);

        // Single 0xA5 with a full-length frame.
        act_len_fix = 10 * CLKS_PER_BIT;
        base_dv = dv_cnt; base_sent = sent_cnt;
        write(8'hA5);
        check("lat_n1_dv", 32'(o_Tx_DV), 0);
        tick();
        check("lat_n2_dv",   32'(o_Tx_DV), 1);
        check("lat_byte",    32'(o_Tx_Byte), 32'h A5);
        wait_idle("single", 200);
        check("a5_frame", 32'(last_frame), 32'b1101001010);
        check("a5_sent",  sent_cnt - base_sent, 1);
        check("a5_dv",    dv_cnt - base_dv, 1);

        // Burst of 16 while the transmitter reports busy, then drain.
        act_len_fix = 4;
        hold_active = 1'b1;
        base_dv = dv_cnt; base_sent = sent_cnt;
        for (int i = 1; i <= 16; i++) write(8'(i));
        check("burst_full",  32'(o_Full), 1);
        check("burst_level", 32'(o_Level), 16);
        check("burst_ovf",   32'(o_Overflow), 0);
        cap.delete();
        hold_active = 1'b0;
        wait_idle("burst", 600);
        check("burst_dv",   dv_cnt - base_dv, 16);
        check("burst_sent", sent_cnt - base_sent, 16);
        check("burst_ncap", cap.size(), 16);
        for (int i = 0; i < 16; i++) check("burst_order", 32'(cap[i]), i + 1);

        // Overflow on the 17th write, then a dead transmitter forces a timeout.
        tx_dead = 1'b1;
        hold_active = 1'b1;
        for (int i = 0; i < 17; i++) write(8'(8'h40 + i));
        check("ovf_set",   32'(o_Overflow), 1);
        check("ovf_level", 32'(o_Level), 16);
        hold_active = 1'b0;
        n = 0;
        while (!o_Tx_DV && n < 10) begin tick(); n++; end
        check("tmo_issue", 32'(o_Tx_DV), 1);
        n = 0;
        while (!o_Timeout && n < 40) begin tick(); n++; end
        check("tmo_latency", n, TIMEOUT_CLKS + 2);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(o_Overflow), 0);
        check("clr_tmo", 32'(o_Timeout), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tx_dead = 1'b0;
        tick();

        // Write coincident with a pop at level 3.
        act_len_fix = 3;
        hold_active = 1'b1;
        for (int i = 0; i < 3; i++) write(8'(8'h71 + i));
        check("coinc_pre", 32'(o_Level), 3);
        hold_active = 1'b0;
        write(8'h74);
        check("coinc_level", 32'(o_Level), 3);
        check("coinc_dv",    32'(o_Tx_DV), 1);
        wait_idle("coinc", 300);

        // Two bytes through the two-cycle done window.
        base_dv = dv_cnt; base_sent = sent_cnt;
        write(8'h5A);
        write(8'hC3);
        wait_idle("gap", 200);
        check("gap_dv",   dv_cnt - base_dv, 2);
        check("gap_sent", sent_cnt - base_sent, 2);

        // Reset while the second of four bytes is being transmitted.
        act_len_fix = 10 * CLKS_PER_BIT;
        base_dv = dv_cnt;
        for (int i = 0; i < 4; i++) write(8'(8'h81 + i));
        n = 0;
        while (dv_cnt - base_dv < 2 && n < 400) begin tick(); n++; end
        check("mid_byte2", dv_cnt - base_dv, 2);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_level", 32'(o_Level), 0);
        check("mid_rst_empty", 32'(o_Empty), 1);
        check("mid_rst_full",  32'(o_Full), 0);
        check("mid_rst_dv",    32'(o_Tx_DV), 0);
        check("mid_rst_byte",  32'(o_Tx_Byte), 0);
        check("mid_rst_busy",  32'(o_Busy), 0);
        check("mid_rst_sent",  32'(o_Byte_Sent), 0);
        rst_n = 1'b1;
        base_dv = dv_cnt;
        repeat (100) tick();
        check("post_rst_no_dv", dv_cnt - base_dv, 0);

        // Randomised traffic with random transmitter timing and dropped DVs.
        tx_rand = 1'b1;
        repeat (800) begin
            wr_en   = ($urandom_range(2) == 0);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(19) == 0);
            tick();
        end
        wr_en = 1'b0;
        clr_ovf = 1'b0;
        wait_idle("rand", 2000);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
